// File: rtl/md_pkg.sv
// Shared types for the iterative multiply/divide unit: operation codes,
// controller states and small decode helpers.
package md_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } md_state_t;

    localparam int MD_WIDTH = 32;

    function automatic logic is_div_op(input md_op_t op);
        return op[1];
    endfunction

    function automatic logic is_signed_op(input md_op_t op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/md_datapath.sv
// Iteration datapath: shift-add multiply on a 2W accumulator, or restoring
// divide with the quotient shifted in from the LSB. Operates on magnitudes.
module md_datapath
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic [2*WIDTH-1:0] prod,
    output logic [WIDTH-1:0]   quo,
    output logic [WIDTH-1:0]   rem
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     shifted;
    logic               ge;

    always_comb begin
        add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
        // Partial remainder is WIDTH+1 bits wide before the trial subtract;
        // after it the remainder always fits back into WIDTH bits.
        shifted = {rem_q, quo_q[WIDTH-1]};
        ge      = shifted >= {1'b0, opnd_q};

        acc_d  = acc_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        opnd_d = opnd_q;

        if (load) begin
            opnd_d = is_div ? b_in : a_in;
            acc_d  = is_div ? '0 : {{WIDTH{1'b0}}, b_in};
            quo_d  = is_div ? a_in : '0;
            rem_d  = '0;
        end else if (step) begin
            if (is_div) begin
                rem_d = WIDTH'(ge ? shifted - {1'b0, opnd_q} : shifted);
                quo_d = {quo_q[WIDTH-2:0], ge};
            end else begin
                acc_d = {add_sum, acc_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            opnd_q <= '0;
        end else begin
            acc_q  <= acc_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            opnd_q <= opnd_d;
        end
    end

    assign prod = acc_q;
    assign quo  = quo_q;
    assign rem  = rem_q;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU with architectural HI/LO registers.
// Controller, sign handling, HI/LO and flags live here; iteration in md_datapath.
module mult_div_unit
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       md_op,
    input  logic [WIDTH-1:0] data_in1,
    input  logic [WIDTH-1:0] data_in2,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_q, div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;

    md_op_t             op_in;
    logic               sa, sb, in_div, b_zero;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    assign op_in  = md_op_t'(md_op);
    assign in_div = is_div_op(op_in);
    assign b_zero = (data_in2 == '0);
    assign sa     = is_signed_op(op_in) & data_in1[WIDTH-1];
    assign sb     = is_signed_op(op_in) & data_in2[WIDTH-1];
    assign mag_a  = sa ? -data_in1 : data_in1;
    assign mag_b  = sb ? -data_in2 : data_in2;

    md_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk    (clk),
        .reset  (reset),
        .load   (state_q == IDLE && start),
        .step   (state_q == RUN),
        .is_div (state_q == IDLE ? in_div : div_q),
        .a_in   (mag_a),
        .b_in   (mag_b),
        .prod   (prod),
        .quo    (quo),
        .rem    (rem)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    div_d      = in_div;
                    // A zero divisor leaves the all-ones quotient uncorrected.
                    neg_res_d  = (sa ^ sb) & ~(in_div & b_zero);
                    neg_rem_d  = sa;
                    div_zero_d = in_div & b_zero;
                    cnt_d      = '0;
                    state_d    = RUN;
                end else begin
                    if (mthi) hi_d = data_in1;
                    if (mtlo) lo_d = data_in1;
                end
            end
            RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                if (div_q) begin
                    lo_d = neg_res_q ? -quo : quo;
                    hi_d = neg_rem_q ? -rem : rem;
                end else begin
                    {hi_d, lo_d} = neg_res_q ? -prod : prod;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_q      <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases from the test plan
// plus randomized back-to-back operations against an arithmetic model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset, start, mthi, mtlo;
    logic [1:0]  md_op;
    logic [31:0] d1, d2;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int tests = 0;
    int fails = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .data_in1 (d1),
        .data_in2 (d2),
        .mthi     (mthi),
        .mtlo     (mtlo),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns {hi, lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (op)
            2'b00: return 64'(sa * sb);
            2'b01: return ua * ub;
            default: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (op == 2'b10) begin
                    q = sa / sb;
                    r = sa % sb;
                    return {r[31:0], q[31:0]};
                end
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit mt_with_start, input bit inject);
        logic [63:0] exp;
        logic [31:0] old_hi, old_lo;
        logic        exp_dz;
        int          k, busy_cnt;
        bit          seen;
        exp    = model(op, a, b);
        exp_dz = op[1] && (b == 32'h0);
        old_hi = hi;
        old_lo = lo;
        md_op  = op;
        d1     = a;
        d2     = b;
        start  = 1'b1;
        mthi   = mt_with_start;
        mtlo   = mt_with_start;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        d1 = $urandom; d2 = $urandom; md_op = 2'($urandom);
        if (mt_with_start) begin
            check("start_beats_mthi", {32'h0, hi}, {32'h0, old_hi});
            check("start_beats_mtlo", {32'h0, lo}, {32'h0, old_lo});
        end
        if (!exp_dz) check("div_zero_clear_on_start", {63'h0, div_zero}, 64'h0);
        k = 0; busy_cnt = 0; seen = 0;
        while (!seen && k < 100) begin
            if (done) seen = 1;
            else begin
                if (busy) busy_cnt++;
                if (inject && k == 5) begin
                    mthi = 1'b1; mtlo = 1'b1; start = 1'b1;
                end
                @(posedge clk); #1;
                k++;
                mthi = 1'b0; mtlo = 1'b0; start = 1'b0;
            end
        end
        check("done_seen", {63'h0, seen}, 64'h1);
        check("latency", 64'(k), 64'd33);
        check("busy_cycles", 64'(busy_cnt), 64'd33);
        check("busy_low_in_done", {63'h0, busy}, 64'h0);
        check("hi", {32'h0, hi}, {32'h0, exp[63:32]});
        check("lo", {32'h0, lo}, {32'h0, exp[31:0]});
        check("div_zero", {63'h0, div_zero}, {63'h0, exp_dz});
    endtask

    initial begin
        int cnt_busy, cnt_done;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        md_op = 2'b00; d1 = '0; d2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", {32'h0, hi}, 64'h0);
        check("rst_lo", {32'h0, lo}, 64'h0);
        check("rst_busy", {63'h0, busy}, 64'h0);
        check("rst_done", {63'h0, done}, 64'h0);
        check("rst_div_zero", {63'h0, div_zero}, 64'h0);
        reset = 1'b0;

        // MTHI / MTLO in IDLE
        d1 = 32'h1234_5678; mthi = 1'b1;
        @(posedge clk); #1; mthi = 1'b0;
        check("mthi", {32'h0, hi}, 64'h1234_5678);
        d1 = 32'hCAFE_BABE; mtlo = 1'b1;
        @(posedge clk); #1; mtlo = 1'b0;
        check("mtlo", {32'h0, lo}, 64'hCAFE_BABE);
        check("mtlo_keeps_hi", {32'h0, hi}, 64'h1234_5678);
        d1 = 32'hA5A5_0F0F; mthi = 1'b1; mtlo = 1'b1;
        @(posedge clk); #1; mthi = 1'b0; mtlo = 1'b0;
        check("mt_both_hi", {32'h0, hi}, 64'hA5A5_0F0F);
        check("mt_both_lo", {32'h0, lo}, 64'hA5A5_0F0F);

        // Directed operations
        run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 1'b0);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(2'b11, 32'd100, 32'd0, 1'b0, 1'b0);
        run_op(2'b10, 32'hFFFF_FF00, 32'd0, 1'b0, 1'b0);
        run_op(2'b00, 32'd6, 32'd7, 1'b0, 1'b0);

        // MT and start pulsed mid-run are ignored and never replayed
        run_op(2'b00, 32'h0001_2345, 32'hFFFF_0003, 1'b0, 1'b1);
        cnt_busy = 0; cnt_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (busy) cnt_busy++;
            if (done) cnt_done++;
        end
        check("no_replay_busy", 64'(cnt_busy), 64'd0);
        check("no_replay_done", 64'(cnt_done), 64'd0);

        // Reset mid-operation
        md_op = 2'b00; d1 = 32'd1234; d2 = 32'd5678; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (9) @(posedge clk);
        #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        check("abort_busy", {63'h0, busy}, 64'h0);
        check("abort_hi", {32'h0, hi}, 64'h0);
        check("abort_lo", {32'h0, lo}, 64'h0);
        cnt_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) cnt_done++;
        end
        check("abort_no_done", 64'(cnt_done), 64'd0);

        // Randomized back-to-back operations
        for (int i = 0; i < 16; i++) begin
            rop = 2'($urandom);
            ra  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            rb  = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 2) == 0) rb = 32'($urandom_range(1, 300));
            run_op(rop, ra, rb, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
